// File: rtl/uart_tx_cfg_pkg.sv
// uart_tx_cfg_pkg: shared types for the configurable UART transmitter.
// Holds the FSM state encoding, parity modes and a width-aware parity helper.
package uart_tx_cfg_pkg;

   typedef enum logic [2:0] {
      s_IDLE          = 3'd0,
      s_TX_START_BIT  = 3'd1,
      s_TX_DATA_BITS  = 3'd2,
      s_TX_PARITY_BIT = 3'd3,
      s_TX_STOP_BIT   = 3'd4,
      s_CLEANUP       = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   // Parity over the low 'width' bits of w; odd inverts the even result.
   function automatic logic calc_parity(
      input logic [8:0] w,
      input int         width,
      input logic       odd
   );
      logic p;
      p = 1'b0;
      for (int i = 0; i < 9; i++)
         if (i < width) p = p ^ w[i];
      return p ^ odd;
   endfunction

endpackage

// File: rtl/Comparator_N_bits.sv
// Comparator_N_bits: N-bit equality comparator.
// Ports: a, b (operands), eq (high when a == b).
module Comparator_N_bits #(
   parameter int N = 3
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         eq
);

   assign eq = (a == b);

endmodule

// File: rtl/uart_tx_cfg_mux.sv
// uart_tx_cfg_mux: selects the serial line level for a given FSM state.
// Ports: state, word (latched data), idx (bit index), par (parity bit),
// line (level to register onto the pad).
module uart_tx_cfg_mux
   import uart_tx_cfg_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  state_t               state,
   input  logic [DATA_BITS-1:0] word,
   input  logic [3:0]           idx,
   input  logic                 par,
   output logic                 line
);

   localparam logic [2:0] ST_START = s_TX_START_BIT;
   localparam logic [2:0] ST_DATA  = s_TX_DATA_BITS;
   localparam logic [2:0] ST_PAR   = s_TX_PARITY_BIT;

   logic is_start;
   logic is_data;
   logic is_par;
   logic data_bit;

   Comparator_N_bits #(.N(3)) u_cmp_start (
      .a  (state),
      .b  (ST_START),
      .eq (is_start)
   );

   Comparator_N_bits #(.N(3)) u_cmp_data (
      .a  (state),
      .b  (ST_DATA),
      .eq (is_data)
   );

   Comparator_N_bits #(.N(3)) u_cmp_par (
      .a  (state),
      .b  (ST_PAR),
      .eq (is_par)
   );

   // Only indices below DATA_BITS can ever select a latch bit.
   always_comb begin
      data_bit = 1'b1;
      for (int i = 0; i < DATA_BITS; i++)
         if (idx == 4'(i)) data_bit = word[i];
   end

   always_comb begin
      line = 1'b1;
      if (is_start)     line = 1'b0;
      else if (is_data) line = data_bit;
      else if (is_par)  line = par;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (start, DATA_BITS LSB-first,
// optional parity, 1-2 stop bits). Ports: i_Clock, i_Reset (async high),
// i_Tx_DV/i_Tx_Byte (request), o_Tx_Active, o_Tx_Serial, o_Tx_Done.
module uart_tx_cfg
   import uart_tx_cfg_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Tx_DV,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Done
);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
   end

   localparam int            CW    = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    D_END = 4'(DATA_BITS - 1);
   localparam logic [3:0]    S_END = 4'(STOP_BITS - 1);
   localparam logic          ODD   = (PARITY == int'(PAR_ODD));

   state_t               state, nstate;
   logic [CW-1:0]        cnt, ncnt;
   logic [3:0]           idx, nidx;
   logic [DATA_BITS-1:0] word, nword;
   logic                 par, npar;
   logic                 tick;
   logic                 line;

   assign tick = (cnt == LAST);

   always_comb begin
      nstate = state;
      ncnt   = cnt;
      nidx   = idx;
      nword  = word;
      npar   = par;
      unique case (state)
         s_IDLE: begin
            ncnt = '0;
            nidx = '0;
            if (i_Tx_DV) begin
               nword  = i_Tx_Byte;
               npar   = calc_parity(9'(i_Tx_Byte), DATA_BITS, ODD);
               nstate = s_TX_START_BIT;
            end
         end
         s_TX_START_BIT: begin
            ncnt = cnt + CW'(1);
            if (tick) begin
               ncnt   = '0;
               nstate = s_TX_DATA_BITS;
            end
         end
         s_TX_DATA_BITS: begin
            ncnt = cnt + CW'(1);
            if (tick) begin
               ncnt = '0;
               nidx = idx + 4'd1;
               if (idx == D_END) begin
                  nidx   = '0;
                  nstate = (PARITY != 0) ? s_TX_PARITY_BIT
                                         : s_TX_STOP_BIT;
               end
            end
         end
         s_TX_PARITY_BIT: begin
            ncnt = cnt + CW'(1);
            if (tick) begin
               ncnt   = '0;
               nstate = s_TX_STOP_BIT;
            end
         end
         // idx doubles as the stop-bit counter.
         s_TX_STOP_BIT: begin
            ncnt = cnt + CW'(1);
            if (tick) begin
               ncnt = '0;
               nidx = idx + 4'd1;
               if (idx == S_END) begin
                  nidx   = '0;
                  nstate = s_CLEANUP;
               end
            end
         end
         s_CLEANUP: nstate = s_IDLE;
         default:   nstate = s_IDLE;
      endcase
   end

   // Line level is chosen from the state being entered so the flop
   // presents it in the same cycle the state takes effect.
   uart_tx_cfg_mux #(.DATA_BITS(DATA_BITS)) u_mux (
      .state (nstate),
      .word  (nword),
      .idx   (nidx),
      .par   (npar),
      .line  (line)
   );

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state       <= s_IDLE;
         cnt         <= '0;
         idx         <= '0;
         word        <= '0;
         par         <= 1'b0;
         o_Tx_Serial <= 1'b1;
         o_Tx_Active <= 1'b0;
         o_Tx_Done   <= 1'b0;
      end else begin
         state       <= nstate;
         cnt         <= ncnt;
         idx         <= nidx;
         word        <= nword;
         par         <= npar;
         o_Tx_Serial <= line;
         o_Tx_Active <= (nstate != s_IDLE) && (nstate != s_CLEANUP);
         o_Tx_Done   <= (nstate == s_CLEANUP);
      end
   end

endmodule
